// File: rtl/uart_tx.sv
// 8N1 UART transmitter: LSB first, idle-high line, clocks-per-bit divisor latched per frame.
// Outputs are registered; once started, a frame always runs through its stop bit.
module uart_tx #(
    parameter int unsigned BAUD_W = 20,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic              i_set,
    input  logic [DATA_W-1:0] i_din,
    input  logic [BAUD_W-1:0] i_baud,
    output logic              o_tx_en,
    output logic              o_tx_out
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   r_cnt;
    logic [IDX_W-1:0]    r_bit;

    logic [BAUD_W-1:0]   w_baud_l;
    logic [BAUD_W-1:0]   w_reload;
    logic                w_start;
    logic                w_bit_done;
    logic                w_last_bit;
    logic [IDX_W-1:0]    w_next_bit;

    // A zero divisor would never let the down-counter expire cleanly, so it acts as 1.
    assign w_baud_l   = (i_baud == '0) ? BAUD_W'(1) : i_baud;
    assign w_reload   = r_baud - BAUD_W'(1);
    assign w_start    = i_sel & i_set;
    assign w_bit_done = (r_cnt == '0);
    assign w_last_bit = (r_bit == IDX_W'(DATA_W - 1));
    assign w_next_bit = r_bit + IDX_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_baud   <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            o_tx_en  <= 1'b0;
            o_tx_out <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    o_tx_en  <= 1'b0;
                    o_tx_out <= 1'b1;
                    r_bit    <= '0;
                    if (w_start) begin
                        r_shift  <= i_din;
                        r_baud   <= w_baud_l;
                        r_cnt    <= w_baud_l - BAUD_W'(1);
                        r_state  <= StStart;
                        o_tx_en  <= 1'b1;
                        o_tx_out <= 1'b0;
                    end
                end
                StStart: begin
                    if (w_bit_done) begin
                        r_state  <= StData;
                        r_bit    <= '0;
                        r_cnt    <= w_reload;
                        o_tx_out <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - BAUD_W'(1);
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        r_cnt <= w_reload;
                        if (w_last_bit) begin
                            r_state  <= StStop;
                            o_tx_out <= 1'b1;
                        end else begin
                            r_bit    <= w_next_bit;
                            o_tx_out <= r_shift[w_next_bit];
                        end
                    end else begin
                        r_cnt <= r_cnt - BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (w_bit_done) begin
                        r_state  <= StIdle;
                        o_tx_en  <= 1'b0;
                        o_tx_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    o_tx_en  <= 1'b0;
                    o_tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus queues expected frames; a negedge monitor rebuilds each frame
// from the line and checks length, per-cycle levels, decoded byte and inter-frame gap.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int BAUD_W = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sel = 1'b0;
    logic              set = 1'b0;
    logic [7:0]        din = '0;
    logic [BAUD_W-1:0] baud = '0;
    logic              tx_en;
    logic              tx_out;

    uart_tx #(
        .BAUD_W(BAUD_W),
        .DATA_W(8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sel   (sel),
        .i_set   (set),
        .i_din   (din),
        .i_baud  (baud),
        .o_tx_en (tx_en),
        .o_tx_out(tx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         baud;
        int         gap;    // required idle cycles before this frame, 0 = don't care
        bit         abort;  // frame is expected to be cut short by reset
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   in_frame = 1'b0;
    bit   wave[$];
    int   idle_len = 0;
    int   idle_bad = 0;
    int   rst_bad  = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int b, input int g, input bit ab);
        exp_t e;
        e.data  = d;
        e.baud  = b;
        e.gap   = g;
        e.abort = ab;
        exp_q.push_back(e);
    endtask

    task automatic check_frame();
        int         len;
        int         bad_at;
        int         exp_lvl;
        int         j;
        int         idx;
        logic [7:0] got;
        len = wave.size();
        check("frame_not_aborted", int'(cur.abort), 0);
        check("frame_len", len, 10 * cur.baud);
        bad_at = -1;
        for (int k = 0; k < len && k < 10 * cur.baud; k++) begin
            j = k / cur.baud;
            exp_lvl = (j == 0) ? 0 : (j == 9) ? 1 : int'(cur.data[j-1]);
            if (bad_at < 0 && int'(wave[k]) != exp_lvl) bad_at = k;
        end
        check("frame_first_bad_cycle", bad_at, -1);
        got = '0;
        for (int b = 0; b < 8; b++) begin
            idx = (b + 1) * cur.baud + cur.baud / 2;
            if (idx < len) got[b] = wave[idx];
        end
        check("frame_byte", int'(got), int'(cur.data));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (have_cur) check("abort_expected", int'(cur.abort), 1);
            end
            if (tx_en !== 1'b0 || tx_out !== 1'b1) rst_bad++;
            idle_len = 0;
        end else if (tx_en === 1'b1) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                wave.delete();
                if (exp_q.size() == 0) begin
                    have_cur = 1'b0;
                    check("unexpected_frame_q_size", 0, 1);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    if (cur.gap != 0) check("frame_gap", idle_len, cur.gap);
                end
            end
            wave.push_back(tx_out);
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (have_cur) check_frame();
                idle_len = 0;
            end
            if (tx_out !== 1'b1) idle_bad++;
            idle_len++;
        end
    end

    task automatic pulse_set();
        set = 1'b1;
        @(posedge clk);
        #1 set = 1'b0;
    endtask

    initial begin
        // Reset with arbitrary, request-asserting inputs
        #1;
        rst  = 1'b1;
        sel  = 1'b1;
        set  = 1'b1;
        din  = 8'hFF;
        baud = 7;
        @(posedge clk);
        #1 check("rst_c1_tx_out", int'(tx_out), 1);
        check("rst_c1_tx_en", int'(tx_en), 0);
        @(posedge clk);
        #1 check("rst_c2_tx_out", int'(tx_out), 1);
        check("rst_c2_tx_en", int'(tx_en), 0);
        rst = 1'b0;
        set = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("post_rst_tx_en", int'(tx_en), 0);
        check("post_rst_tx_out", int'(tx_out), 1);

        // Single frame, 0x33 at 20 cycles/bit
        baud = 20;
        din  = 8'h33;
        sel  = 1'b1;
        push_exp(8'h33, 20, 0, 1'b0);
        pulse_set();
        check("single_latency_tx_en", int'(tx_en), 1);
        check("single_latency_tx_out", int'(tx_out), 0);
        repeat (205) @(posedge clk);
        #1 check("single_end_tx_en", int'(tx_en), 0);
        check("single_end_tx_out", int'(tx_out), 1);

        // Held request: two frames separated by exactly one idle cycle
        push_exp(8'h33, 20, 0, 1'b0);
        push_exp(8'h33, 20, 1, 1'b0);
        set = 1'b1;
        repeat (230) @(posedge clk);
        #1 set = 1'b0;
        repeat (200) @(posedge clk);
        #1 check("held_end_tx_en", int'(tx_en), 0);
        check("held_q_empty", exp_q.size(), 0);

        // Gating by sel
        sel  = 1'b0;
        set  = 1'b1;
        din  = 8'h5A;
        baud = 3;
        repeat (50) @(posedge clk);
        #1 check("gated_tx_en", int'(tx_en), 0);
        check("gated_tx_out", int'(tx_out), 1);
        push_exp(8'h5A, 3, 0, 1'b0);
        sel = 1'b1;
        @(posedge clk);
        #1 check("ungated_latency_tx_en", int'(tx_en), 1);
        set = 1'b0;
        repeat (35) @(posedge clk);
        #1 check("gate_q_empty", exp_q.size(), 0);

        // Latch integrity: mid-frame din/baud changes must not leak in
        baud = 20;
        din  = 8'hA5;
        push_exp(8'hA5, 20, 0, 1'b0);
        pulse_set();
        repeat (50) @(posedge clk);
        #1;
        din  = 8'hFF;
        baud = 5;
        repeat (160) @(posedge clk);
        #1 check("latch_end_tx_en", int'(tx_en), 0);
        check("latch_q_empty", exp_q.size(), 0);

        // Minimum divisor: baud 0 and 1 both give 10-cycle frames
        baud = 0;
        din  = 8'h81;
        push_exp(8'h81, 1, 0, 1'b0);
        pulse_set();
        repeat (15) @(posedge clk);
        #1;
        baud = 1;
        din  = 8'h6C;
        push_exp(8'h6C, 1, 0, 1'b0);
        pulse_set();
        repeat (15) @(posedge clk);
        #1 check("min_baud_q_empty", exp_q.size(), 0);

        // Reset mid-frame while a data 0 is on the line
        baud = 10;
        din  = 8'hF0;
        push_exp(8'hF0, 10, 0, 1'b1);
        pulse_set();
        repeat (34) @(posedge clk);
        #1 check("pre_rst_tx_out", int'(tx_out), 0);
        #1 rst = 1'b1;
        #1 check("async_rst_tx_out", int'(tx_out), 1);
        check("async_rst_tx_en", int'(tx_en), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("after_rst_tx_en", int'(tx_en), 0);
        check("after_rst_tx_out", int'(tx_out), 1);
        baud = 4;
        din  = 8'h3C;
        push_exp(8'h3C, 4, 0, 1'b0);
        pulse_set();
        repeat (45) @(posedge clk);
        #1 check("fresh_end_tx_en", int'(tx_en), 0);

        check("final_q_empty", exp_q.size(), 0);
        check("final_not_in_frame", int'(in_frame), 0);
        check("idle_line_violations", idle_bad, 0);
        check("reset_output_violations", rst_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterless-protocol UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Bit period is set at run time by a clocks-per-bit divisor.
- Sits between a bus/register interface (sel/set/din/baud) and the serial TX pin.
- Exposes a busy/active flag (tx_en) for flow control and pin-driver enable.

Parameters:
- BAUD_W, 20, width of the baud divisor input.
- DATA_W, 8, data bits per frame; fixed at 8 for this block.

Ports:
- clk     input   1       system clock, rising-edge active
- rst     input   1       reset; asynchronous, active-high
- sel     input   1       block select; a frame may start only while high
- set     input   1       transmit request, level-sensitive
- din     input   8       byte to transmit
- baud    input   BAUD_W  clock cycles per serial bit
- tx_en   output  1       high while a frame is on the line (start bit through stop bit)
- tx_out  output  1       serial line output, idle high

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst is asynchronous and active-high. While asserted: state=IDLE, tx_out=1, tx_en=0, all counters cleared.
  - Reset asserted mid-frame aborts the frame immediately, with the line forced high.
- Outputs are registered.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE
  - tx_out=1, tx_en=0.
  - On a rising edge where sel=1 and set=1: latch din into a shift register, latch baud into the divisor register, go to START.
  - A baud value of 0 is latched as 1.
- START
  - tx_out=0, tx_en=1 for exactly baud_l cycles, then go to DATA with bit index 0.
- DATA
  - tx_out = shift_reg[bit index], LSB first.
  - Each bit is held exactly baud_l cycles.
  - After bit 7 completes, go to STOP.
- STOP
  - tx_out=1, tx_en=1 for baud_l cycles, then go to IDLE.
- Latency
  - tx_out falls and tx_en rises on the first clock edge after the qualifying sel&set sample (1-cycle latency).
  - Total frame = 10*baud_l cycles with tx_en=1.
- Back-to-back frames
  - IDLE always lasts at least 1 cycle (tx_en=0, tx_out=1) between frames.
  - If sel&set are still high in that IDLE cycle, the next frame starts from that cycle, re-latching din and baud.
- Mid-frame input changes
  - din and baud changes during a frame do not affect it.
  - sel or set deasserting during a frame does not abort it; the frame always completes.
- Bit timing
  - Per-bit down-counter loaded with baud_l-1; the bit advances when the counter reaches 0.
  - The counter is BAUD_W bits wide; no overflow is possible.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> tx_out=1, tx_en=0 throughout reset and afterwards while set=0.
- Single frame: baud=20, sel=1, din=0x33, pulse set for 1 cycle.
  - Line: start 0, then bits 1,1,0,0,1,1,0,0, then stop 1.
  - Each level lasts exactly 20 cycles.
  - tx_en high for exactly 200 cycles, then tx_out=1 and tx_en=0.
- Held request: baud=20, din=0x33, sel=1, set held 230 cycles, then low.
  - First frame: 200 cycles.
  - tx_en low for exactly 1 cycle.
  - Second identical frame starts and completes fully even though set drops during it.
  - Line idle afterwards.
- Gating: sel=0, set=1 for 50 cycles -> no frame, tx_en=0, tx_out=1.
  - Raising sel then starts a frame on the next edge.
- Latch integrity and minimum divisor:
  - Start a frame with baud=20, din=0xA5; change din to 0xFF and baud to 5 mid-frame -> 0xA5 is transmitted at 20 cycles/bit.
  - Separately, baud=0 and baud=1 each produce 10-cycle frames.
- Reset mid-frame: assert rst during DATA -> tx_out=1 and tx_en=0 immediately (asynchronous).
  - After release with set=0, the line stays idle.
  - A fresh request transmits correctly.
